// File: rtl/reg_scoreboard_decoder_if.sv
`default_nettype none
// ============================================================================
//  Module   : reg_scoreboard_decoder_if
//  Purpose  : Control-unit <-> scoreboard/write-enable decoder signal bundle.
//  Revision : 1.0  initial release
// ============================================================================
interface reg_scoreboard_decoder_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int CNT_WIDTH  = ADDR_WIDTH + 1
);
    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    logic                  flush;
    logic                  issue_valid;
    logic [ADDR_WIDTH-1:0] issue_addr;
    logic                  issue_ready;
    logic                  wb_valid;
    logic [ADDR_WIDTH-1:0] wb_addr;
    logic [ADDR_WIDTH-1:0] rs_addr;
    logic [ADDR_WIDTH-1:0] rt_addr;
    logic                  rs_busy;
    logic                  rt_busy;
    logic [NUM_REGS-1:0]   onehot_we;
    logic [NUM_REGS-1:0]   busy_map;
    logic [CNT_WIDTH-1:0]  busy_count;
    logic                  wb_err;

    modport master (
        output flush, issue_valid, issue_addr, wb_valid, wb_addr, rs_addr, rt_addr,
        input  issue_ready, rs_busy, rt_busy, onehot_we, busy_map, busy_count, wb_err
    );

    modport slave (
        input  flush, issue_valid, issue_addr, wb_valid, wb_addr, rs_addr, rt_addr,
        output issue_ready, rs_busy, rt_busy, onehot_we, busy_map, busy_count, wb_err
    );
endinterface
`default_nettype wire

// File: rtl/reg_scoreboard_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : reg_scoreboard_decoder
//  Purpose  : Registered one-hot register write-enable decode plus a busy
//             scoreboard of outstanding producers for rs/rt hazard checks.
//  Revision : 1.0  initial release
// ============================================================================
module reg_scoreboard_decoder #(
    parameter int ADDR_WIDTH         = 5,
    parameter int ZERO_REG_HARDWIRED = 1,
    parameter int CNT_WIDTH          = ADDR_WIDTH + 1
) (
    input  wire logic               clk,
    input  wire logic               reset,
    reg_scoreboard_decoder_if.slave bus
);
    localparam int   NUM_REGS  = 2 ** ADDR_WIDTH;
    localparam logic C_ZERO_HW = (ZERO_REG_HARDWIRED != 0);

    logic [NUM_REGS-1:0]  onehot_we_q,  onehot_we_d;
    logic [NUM_REGS-1:0]  busy_map_q,   busy_map_d;
    logic [CNT_WIDTH-1:0] busy_count_q, busy_count_d;
    logic                 wb_err_q,     wb_err_d;

    logic w_issue_ready;
    logic w_issue_acc;
    logic w_issue_live;
    logic w_wb_live;
    logic w_same_addr;
    logic w_set;
    logic w_clr;

    assign w_same_addr   = (bus.issue_addr == bus.wb_addr);
    assign w_issue_ready = ~bus.flush &
                           (~busy_map_q[bus.issue_addr] | (bus.wb_valid & w_same_addr));
    assign w_issue_acc   = bus.issue_valid & w_issue_ready;

    // Register 0 accepts issues and writebacks but never becomes busy or enabled.
    assign w_issue_live = w_issue_acc &
                          ~(C_ZERO_HW & (bus.issue_addr == {ADDR_WIDTH{1'b0}}));
    assign w_wb_live    = bus.wb_valid &
                          ~(C_ZERO_HW & (bus.wb_addr == {ADDR_WIDTH{1'b0}}));

    // Incremental popcount: a colliding issue keeps the bit, so no clear is counted.
    assign w_set = w_issue_live & ~busy_map_q[bus.issue_addr];
    assign w_clr = w_wb_live & busy_map_q[bus.wb_addr] & ~(w_issue_acc & w_same_addr);

    always_comb begin
        busy_map_d = busy_map_q;
        if (w_wb_live)
            busy_map_d[bus.wb_addr] = 1'b0;
        if (w_issue_live)
            busy_map_d[bus.issue_addr] = 1'b1;
        if (bus.flush)
            busy_map_d = '0;

        if (bus.flush)
            busy_count_d = '0;
        else
            busy_count_d = busy_count_q + CNT_WIDTH'(w_set) - CNT_WIDTH'(w_clr);

        onehot_we_d = w_wb_live ? (NUM_REGS'(1) << bus.wb_addr) : '0;
        wb_err_d    = wb_err_q | (w_wb_live & ~busy_map_q[bus.wb_addr]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            onehot_we_q  <= '0;
            busy_map_q   <= '0;
            busy_count_q <= '0;
            wb_err_q     <= 1'b0;
        end else begin
            onehot_we_q  <= onehot_we_d;
            busy_map_q   <= busy_map_d;
            busy_count_q <= busy_count_d;
            wb_err_q     <= wb_err_d;
        end
    end

    assign bus.issue_ready = w_issue_ready;
    assign bus.rs_busy     = busy_map_q[bus.rs_addr];
    assign bus.rt_busy     = busy_map_q[bus.rt_addr];
    assign bus.onehot_we   = onehot_we_q;
    assign bus.busy_map    = busy_map_q;
    assign bus.busy_count  = busy_count_q;
    assign bus.wb_err      = wb_err_q;
endmodule
`default_nettype wire

// File: tb/tb_reg_scoreboard_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reg_scoreboard_decoder
//  Purpose  : Directed self-checking bench for reg_scoreboard_decoder.
//  Revision : 1.0  initial release
// ============================================================================
module tb_reg_scoreboard_decoder;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;

    reg_scoreboard_decoder_if #(.ADDR_WIDTH(5)) bus ();

    reg_scoreboard_decoder #(
        .ADDR_WIDTH         (5),
        .ZERO_REG_HARDWIRED (1),
        .CNT_WIDTH          (6)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.flush       = 1'b0;
        bus.issue_valid = 1'b0;
        bus.wb_valid    = 1'b0;
    endtask

    task automatic issue(input logic [4:0] a);
        bus.issue_valid = 1'b1;
        bus.issue_addr  = a;
        step();
        bus.issue_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] e;
        n_checks = 0;
        n_pass   = 0;
        reset    = 1'b1;
        idle();
        bus.issue_addr = '0;
        bus.wb_addr    = '0;
        bus.rs_addr    = '0;
        bus.rt_addr    = '0;
        step();
        step();
        reset = 1'b0;
        step();

        check("rst_onehot", bus.onehot_we, 32'h0);
        check("rst_busy",   bus.busy_map, 32'h0);
        check("rst_count",  32'(bus.busy_count), 32'd0);
        check("rst_err",    32'(bus.wb_err), 32'd0);

        // WAW stall and same-cycle issue/wb collision on r5
        bus.issue_valid = 1'b1;
        bus.issue_addr  = 5'd5;
        #1 check("r5_ready1", 32'(bus.issue_ready), 32'd1);
        step();
        check("r5_busy", bus.busy_map, 32'h0000_0020);
        check("r5_ready2", 32'(bus.issue_ready), 32'd0);
        step();
        check("r5_count_stall", 32'(bus.busy_count), 32'd1);
        bus.wb_valid = 1'b1;
        bus.wb_addr  = 5'd5;
        #1 check("r5_ready_coll", 32'(bus.issue_ready), 32'd1);
        step();
        check("r5_busy_coll",  bus.busy_map, 32'h0000_0020);
        check("r5_onehot",     bus.onehot_we, 32'h0000_0020);
        check("r5_count_coll", 32'(bus.busy_count), 32'd1);
        check("r5_err",        32'(bus.wb_err), 32'd0);

        // wb r5 alongside issue r8 (different addresses), then r9, then rs/rt queries
        bus.issue_addr = 5'd8;
        step();
        idle();
        check("r8_busy",  bus.busy_map, 32'h0000_0100);
        check("r8_count", 32'(bus.busy_count), 32'd1);
        issue(5'd9);
        bus.rs_addr = 5'd8;
        bus.rt_addr = 5'd9;
        #1;
        check("rs_busy_a",  32'(bus.rs_busy), 32'd1);
        check("rt_busy_a",  32'(bus.rt_busy), 32'd1);
        check("count_89",   32'(bus.busy_count), 32'd2);
        bus.wb_valid = 1'b1;
        bus.wb_addr  = 5'd8;
        #1 check("rs_no_bypass", 32'(bus.rs_busy), 32'd1);
        step();
        bus.wb_addr = 5'd9;
        check("rs_busy_b",  32'(bus.rs_busy), 32'd0);
        check("rt_busy_b",  32'(bus.rt_busy), 32'd1);
        check("count_9",    32'(bus.busy_count), 32'd1);
        check("onehot_r8",  bus.onehot_we, 32'h0000_0100);
        step();
        idle();
        check("busy_clear", bus.busy_map, 32'h0);

        // Pre-issue r1..r31 and r0, then writeback sweep
        for (int a = 1; a < 32; a++) issue(5'(a));
        check("full_count", 32'(bus.busy_count), 32'd31);
        check("full_map",   bus.busy_map, 32'hFFFF_FFFE);
        bus.issue_addr  = 5'd0;
        bus.issue_valid = 1'b1;
        #1 check("r0_ready", 32'(bus.issue_ready), 32'd1);
        step();
        bus.issue_valid = 1'b0;
        check("r0_never_busy", 32'(bus.busy_map[0]), 32'd0);
        for (int a = 1; a < 32; a++) begin
            bus.wb_valid = 1'b1;
            bus.wb_addr  = 5'(a);
            step();
            e = 32'h1 << a;
            check($sformatf("dec_%0d", a), bus.onehot_we, e);
        end
        bus.wb_addr = 5'd0;
        step();
        idle();
        check("dec_0",      bus.onehot_we, 32'h0);
        check("dec_0_err",  32'(bus.wb_err), 32'd0);
        check("sweep_cnt",  32'(bus.busy_count), 32'd0);
        step();
        check("we_idle",    bus.onehot_we, 32'h0);

        // Flush priority over simultaneous issue and wb
        issue(5'd3);
        issue(5'd4);
        issue(5'd7);
        check("pre_flush", bus.busy_map, 32'h0000_0098);
        bus.flush       = 1'b1;
        bus.issue_valid = 1'b1;
        bus.issue_addr  = 5'd10;
        bus.wb_valid    = 1'b1;
        bus.wb_addr     = 5'd3;
        #1 check("flush_ready", 32'(bus.issue_ready), 32'd0);
        step();
        idle();
        check("flush_map",    bus.busy_map, 32'h0);
        check("flush_count",  32'(bus.busy_count), 32'd0);
        check("flush_onehot", bus.onehot_we, 32'h0000_0008);
        check("flush_err",    32'(bus.wb_err), 32'd0);

        // Sticky wb_err on writeback to a non-busy register
        bus.wb_valid = 1'b1;
        bus.wb_addr  = 5'd12;
        step();
        idle();
        check("err_set",    32'(bus.wb_err), 32'd1);
        check("err_onehot", bus.onehot_we, 32'h0000_1000);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        check("err_sticky", 32'(bus.wb_err), 32'd1);

        // Asynchronous reset mid-cycle
        issue(5'd4);
        issue(5'd5);
        issue(5'd6);
        issue(5'd7);
        check("pre_rst_map", bus.busy_map, 32'h0000_00F0);
        bus.wb_valid = 1'b1;
        bus.wb_addr  = 5'd6;
        step();
        idle();
        #1 reset = 1'b1;
        #1;
        check("arst_map",    bus.busy_map, 32'h0);
        check("arst_onehot", bus.onehot_we, 32'h0);
        check("arst_count",  32'(bus.busy_count), 32'd0);
        check("arst_err",    32'(bus.wb_err), 32'd0);
        step();
        reset = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
